// File: rtl/mem_bus_pkg.sv
// Shared encodings for the RAM bus arbiter: FSM states, bus owners and
// memory command codes.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_COMPLETE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        MNONE  = 2'd0,
        MREAD  = 2'd1,
        MWRITE = 2'd2
    } mem_cmd_e;

endpackage

// File: rtl/mem_bus_arbiter_rr2.sv
// Two-way round-robin picker: requester a is the CPU, b is the debug port.
// force_b gives b strict priority when both are requesting.
module arb_rr2
    import mem_bus_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  owner_e last,
    input  logic   force_b,
    output owner_e grant
);

    always_comb begin
        grant = OWN_CPU;
        if (req_a && req_b) begin
            if (force_b || last == OWN_CPU) begin
                grant = OWN_DBG;
            end
        end else if (req_b) begin
            grant = OWN_DBG;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous-read RAM between the CPU and the debug/loader port
// using a three-state IDLE/ISSUE/COMPLETE sequence per access.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              cpu_halt,
    input  logic              dbg_req,
    input  logic              dbg_write,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              grant_dbg,
    output logic [CNT_W-1:0]  cpu_stall_cnt
);

    state_e            state_q;
    owner_e            owner_q, last_q, pick;
    mem_cmd_e          cmd_q;
    logic              cpu_ack_q, dbg_ack_q, mem_write_q, grant_dbg_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              stall_hit, cap_cpu, cap_dbg;

    arb_rr2 u_pick (
        .req_a   (cpu_req),
        .req_b   (dbg_req),
        .last    (last_q),
        .force_b (cpu_halt),
        .grant   (pick)
    );

    // RAM data is only valid during COMPLETE, so the ack-cycle value bypasses
    // the holding register and is captured into it at the end of the cycle.
    assign cap_cpu     = (state_q == ST_COMPLETE) && (cmd_q == MREAD) && (owner_q == OWN_CPU);
    assign cap_dbg     = (state_q == ST_COMPLETE) && (cmd_q == MREAD) && (owner_q == OWN_DBG);
    assign cpu_rdata_d = cap_cpu ? mem_dout : cpu_rdata_q;
    assign dbg_rdata_d = cap_dbg ? mem_dout : dbg_rdata_q;

    always_comb begin
        stall_hit = (state_q == ST_IDLE) ? (dbg_req && pick == OWN_DBG)
                                         : (owner_q == OWN_DBG);
        stall_d = stall_q;
        if (cpu_req && stall_hit && stall_q != '1) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            last_q      <= OWN_DBG;
            cmd_q       <= MNONE;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            mem_write_q <= 1'b0;
            grant_dbg_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            stall_q     <= '0;
        end else begin
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            mem_write_q <= 1'b0;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            stall_q     <= stall_d;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req || dbg_req) begin
                        state_q     <= ST_ISSUE;
                        owner_q     <= pick;
                        last_q      <= pick;
                        grant_dbg_q <= (pick == OWN_DBG);
                        if (pick == OWN_DBG) begin
                            mem_addr_q  <= dbg_addr;
                            mem_din_q   <= dbg_wdata;
                            mem_write_q <= dbg_write;
                            cmd_q       <= dbg_write ? MWRITE : MREAD;
                        end else begin
                            mem_addr_q  <= cpu_addr;
                            mem_din_q   <= cpu_wdata;
                            mem_write_q <= cpu_write;
                            cmd_q       <= cpu_write ? MWRITE : MREAD;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q   <= ST_COMPLETE;
                    cpu_ack_q <= (owner_q == OWN_CPU);
                    dbg_ack_q <= (owner_q == OWN_DBG);
                end
                ST_COMPLETE: begin
                    state_q     <= ST_IDLE;
                    grant_dbg_q <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    grant_dbg_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ack       = cpu_ack_q;
    assign dbg_ack       = dbg_ack_q;
    assign cpu_rdata     = cpu_rdata_d;
    assign dbg_rdata     = dbg_rdata_d;
    assign mem_addr      = mem_addr_q;
    assign mem_write     = mem_write_q;
    assign mem_din       = mem_din_q;
    assign grant_dbg     = grant_dbg_q;
    assign cpu_stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural synchronous-read RAM.
module tb_mem_bus_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_write, cpu_halt, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dbg_req, dbg_write, dbg_ack;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_write, grant_dbg;
    logic [DW-1:0] mem_din, mem_dout;
    logic [CW-1:0] cpu_stall_cnt;

    logic [DW-1:0] ram [256];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_halt(cpu_halt),
        .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_din(mem_din), .mem_dout(mem_dout),
        .grant_dbg(grant_dbg), .cpu_stall_cnt(cpu_stall_cnt)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Advances until an ack is seen or the budget runs out; n is the ticks taken.
    task automatic wait_ack(input int limit, output int n, output logic c, output logic d);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(cpu_ack || dbg_ack) && n < limit);
        c = cpu_ack;
        d = dbg_ack;
    endtask

    task automatic test_reset();
        tick();
        tests++;
        if ({cpu_ack, dbg_ack, mem_write, grant_dbg} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 0000", {cpu_ack, dbg_ack, mem_write, grant_dbg});
        end
        tests++;
        if ({cpu_rdata, dbg_rdata, mem_addr, mem_din, cpu_stall_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_data: cpu_rdata=%h dbg_rdata=%h addr=%h din=%h stall=%0d want all 0",
                     cpu_rdata, dbg_rdata, mem_addr, mem_din, cpu_stall_cnt);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h0F;
        tick();
        tests++;
        if (mem_addr !== 8'h0F || mem_write !== 1'b0 || cpu_ack !== 1'b0 || dbg_ack !== 1'b0) begin
            fails++;
            $display("FAIL cpu_rd_issue: addr=%h we=%b ack=%b dack=%b want 0f 0 0 0",
                     mem_addr, mem_write, cpu_ack, dbg_ack);
        end
        tick();
        tests++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h0004 || dbg_ack !== 1'b0) begin
            fails++;
            $display("FAIL cpu_rd_ack: ack=%b rdata=%h dack=%b want 1 0004 0", cpu_ack, cpu_rdata, dbg_ack);
        end
        cpu_req = 1'b0;
        tick();
        tests++;
        if (cpu_ack !== 1'b0 || cpu_rdata !== 16'h0004 || dbg_ack !== 1'b0 || cpu_stall_cnt !== 16'd0) begin
            fails++;
            $display("FAIL cpu_rd_hold: ack=%b rdata=%h dack=%b stall=%0d want 0 0004 0 0",
                     cpu_ack, cpu_rdata, dbg_ack, cpu_stall_cnt);
        end
    endtask

    task automatic test_dbg_write_cpu_read();
        dbg_req = 1'b1; dbg_write = 1'b1; dbg_addr = 8'h14; dbg_wdata = 16'h0352;
        tick();
        tests++;
        if (mem_write !== 1'b1 || mem_addr !== 8'h14 || mem_din !== 16'h0352 || grant_dbg !== 1'b1) begin
            fails++;
            $display("FAIL dbg_wr_issue: we=%b addr=%h din=%h gnt=%b want 1 14 0352 1",
                     mem_write, mem_addr, mem_din, grant_dbg);
        end
        tick();
        tests++;
        if (dbg_ack !== 1'b1 || mem_write !== 1'b0 || grant_dbg !== 1'b1 || cpu_ack !== 1'b0) begin
            fails++;
            $display("FAIL dbg_wr_ack: dack=%b we=%b gnt=%b ack=%b want 1 0 1 0",
                     dbg_ack, mem_write, grant_dbg, cpu_ack);
        end
        dbg_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h14;
        tick();
        tick();
        tests++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h0352 || dbg_rdata !== 16'h0000 || grant_dbg !== 1'b0) begin
            fails++;
            $display("FAIL cpu_rd_patched: ack=%b rdata=%h drdata=%h gnt=%b want 1 0352 0000 0",
                     cpu_ack, cpu_rdata, dbg_rdata, grant_dbg);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        int n;
        logic c, d;
        do_reset();
        cpu_halt = 1'b0;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h0F;
        dbg_req = 1'b1; dbg_write = 1'b0; dbg_addr = 8'h14;
        for (int k = 0; k < 6; k++) begin
            wait_ack(6, n, c, d);
            tests++;
            if (c === d || d !== (k % 2 == 1) || n != ((k == 0) ? 2 : 3)) begin
                fails++;
                $display("FAIL rr_grant%0d: cpu_ack=%b dbg_ack=%b ticks=%0d want dbg=%0d ticks=%0d",
                         k, c, d, n, k % 2, (k == 0) ? 2 : 3);
            end
            tests++;
            if ((d && dbg_rdata !== 16'h0352) || (c && cpu_rdata !== 16'h0004)) begin
                fails++;
                $display("FAIL rr_data%0d: cpu_rdata=%h dbg_rdata=%h want 0004/0352", k, cpu_rdata, dbg_rdata);
            end
        end
        tick();
        cpu_req = 1'b0; dbg_req = 1'b0;
        tests++;
        if (cpu_stall_cnt !== 16'd9) begin
            fails++;
            $display("FAIL rr_stall: got %0d want 9", cpu_stall_cnt);
        end
        tick();
    endtask

    task automatic test_halt();
        int n;
        logic c, d;
        do_reset();
        cpu_halt = 1'b1;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h0F;
        dbg_req = 1'b1; dbg_write = 1'b0; dbg_addr = 8'h14;
        for (int k = 0; k < 3; k++) begin
            wait_ack(6, n, c, d);
            tests++;
            if (d !== 1'b1 || c !== 1'b0 || n != ((k == 0) ? 2 : 3)) begin
                fails++;
                $display("FAIL halt_grant%0d: cpu_ack=%b dbg_ack=%b ticks=%0d want dbg only", k, c, d, n);
            end
        end
        tests++;
        if (cpu_stall_cnt !== 16'd8) begin
            fails++;
            $display("FAIL halt_stall: got %0d want 8", cpu_stall_cnt);
        end
        cpu_halt = 1'b0;
        wait_ack(6, n, c, d);
        tests++;
        if (c !== 1'b1 || d !== 1'b0 || n != 3 || cpu_rdata !== 16'h0004) begin
            fails++;
            $display("FAIL halt_release: cpu_ack=%b dbg_ack=%b ticks=%0d rdata=%h want 1 0 3 0004",
                     c, d, n, cpu_rdata);
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        ram[8'h15] = 16'h1111;
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 8'h15; cpu_wdata = 16'hBEEF;
        tick();
        tests++;
        if (mem_write !== 1'b1 || mem_addr !== 8'h15) begin
            fails++;
            $display("FAIL rst_mid_issue: we=%b addr=%h want 1 15", mem_write, mem_addr);
        end
        reset = 1'b1;
        cpu_req = 1'b0;
        #1;
        tests++;
        if (mem_write !== 1'b0 || mem_addr !== 8'h00 || mem_din !== 16'h0000 || cpu_stall_cnt !== 16'd0) begin
            fails++;
            $display("FAIL rst_mid_async: we=%b addr=%h din=%h stall=%0d want 0 00 0000 0",
                     mem_write, mem_addr, mem_din, cpu_stall_cnt);
        end
        tick();
        tests++;
        if (cpu_ack !== 1'b0 || ram[8'h15] !== 16'h1111) begin
            fails++;
            $display("FAIL rst_mid_nowrite: ack=%b ram15=%h want 0 1111", cpu_ack, ram[8'h15]);
        end
        reset = 1'b0;
        tick();
        tick();
        tests++;
        if (cpu_ack !== 1'b0 || mem_write !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_after: ack=%b we=%b want 0 0", cpu_ack, mem_write);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic c, d;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h0F;
        wait_ack(6, n, c, d);
        tests++;
        if (c !== 1'b1 || n != 2 || cpu_rdata !== 16'h0004) begin
            fails++;
            $display("FAIL b2b_first: ack=%b ticks=%0d rdata=%h want 1 2 0004", c, n, cpu_rdata);
        end
        wait_ack(6, n, c, d);
        tests++;
        if (c !== 1'b1 || d !== 1'b0 || n != 3 || cpu_rdata !== 16'h0004) begin
            fails++;
            $display("FAIL b2b_second: ack=%b dack=%b ticks=%0d rdata=%h want 1 0 3 0004", c, d, n, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
        ram[8'h0F] = 16'h0004;
        mem_dout  = '0;
        reset     = 1'b0;
        cpu_req   = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_halt = 1'b0;
        dbg_req   = 1'b0; dbg_write = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        #2 reset = 1'b1;
        tick();
        test_reset();
        test_cpu_read();
        test_dbg_write_cpu_read();
        test_contention();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
